// File: rtl/anti_theft_controller_if.sv
// Signal bundle between the car-security sequencer and the rest of the system.
// The master side drives sensors, ticks and the reprogram pulse.
// The slave side (the controller) returns the siren, LED, pump gate and debug state.
interface anti_theft_controller_if;
  logic       one_hz_enable;
  logic       ignition;
  logic       driver_door;
  logic       passenger_door;
  logic       hood;
  logic       reprogram;
  logic       siren;
  logic       status_led;
  logic       pump_inhibit;
  logic [2:0] state_out;

  modport master (
    output one_hz_enable, ignition, driver_door, passenger_door, hood, reprogram,
    input  siren, status_led, pump_inhibit, state_out
  );

  modport slave (
    input  one_hz_enable, ignition, driver_door, passenger_door, hood, reprogram,
    output siren, status_led, pump_inhibit, state_out
  );
endinterface

// File: rtl/anti_theft_controller.sv
// Central sequencing FSM of the car-security system.
// It arms, triggers and sounds the alarm from ignition/door/hood inputs using a
// shared down-counter that decrements on 1 Hz ticks. All outputs are registered.
// pump_inhibit is ANDed downstream with the fuel pump controller's output.
module anti_theft_controller #(
  parameter int TW                = 4,
  parameter int T_ARM_DELAY       = 6,
  parameter int T_DRIVER_DELAY    = 8,
  parameter int T_PASSENGER_DELAY = 15,
  parameter int T_ALARM_ON        = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  anti_theft_controller_if.slave   bus
);

  localparam logic [2:0] ARMED           = 3'd0;
  localparam logic [2:0] TRIGGERED       = 3'd1;
  localparam logic [2:0] SOUND_ALARM     = 3'd2;
  localparam logic [2:0] DISARMED        = 3'd3;
  localparam logic [2:0] WAIT_DOOR_OPEN  = 3'd4;
  localparam logic [2:0] WAIT_DOOR_CLOSE = 3'd5;
  localparam logic [2:0] ARM_COUNT       = 3'd6;

  localparam logic [TW-1:0] LOAD_ARM       = TW'(T_ARM_DELAY);
  localparam logic [TW-1:0] LOAD_DRIVER    = TW'(T_DRIVER_DELAY);
  localparam logic [TW-1:0] LOAD_PASSENGER = TW'(T_PASSENGER_DELAY);
  localparam logic [TW-1:0] LOAD_ALARM     = TW'(T_ALARM_ON);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] count_q, count_d;
  logic          siren_q, siren_d;
  logic          status_led_q, status_led_d;
  logic          pump_inhibit_q, pump_inhibit_d;

  // Timer control produced by the FSM; a load always wins over a tick.
  logic          load_en;
  logic          clear_en;
  logic [TW-1:0] load_val;
  logic          expired;
  logic          any_open;
  logic          tick;

  assign tick     = bus.one_hz_enable;
  assign any_open = bus.driver_door | bus.passenger_door | bus.hood;
  // A load happens on the edge itself, so the count seen here was never
  // loaded during the current cycle; zero therefore means expired.
  assign expired  = (count_q == '0);

  // Next-state and timer-load decisions; reprogram overrides everything.
  always_comb begin
    state_d  = state_q;
    load_en  = 1'b0;
    clear_en = 1'b0;
    load_val = '0;
    if (bus.reprogram) begin
      state_d  = ARMED;
      clear_en = 1'b1;
    end else begin
      case (state_q)
        ARMED: begin
          if (bus.ignition) begin
            state_d = DISARMED;
          end else if (bus.driver_door) begin
            // Driver opening takes the shorter grace even if others open too.
            state_d  = TRIGGERED;
            load_en  = 1'b1;
            load_val = LOAD_DRIVER;
          end else if (bus.passenger_door || bus.hood) begin
            state_d  = TRIGGERED;
            load_en  = 1'b1;
            load_val = LOAD_PASSENGER;
          end
        end
        TRIGGERED: begin
          // Closing the openings does not cancel the countdown.
          if (bus.ignition) begin
            state_d = DISARMED;
          end else if (expired) begin
            state_d  = SOUND_ALARM;
            load_en  = 1'b1;
            load_val = LOAD_ALARM;
          end
        end
        SOUND_ALARM: begin
          if (bus.ignition) begin
            state_d = DISARMED;
          end else if (any_open) begin
            // Siren tail only starts counting once everything is closed.
            load_en  = 1'b1;
            load_val = LOAD_ALARM;
          end else if (expired) begin
            state_d = ARMED;
          end
        end
        DISARMED: begin
          if (!bus.ignition) begin
            state_d = WAIT_DOOR_OPEN;
          end
        end
        WAIT_DOOR_OPEN: begin
          if (bus.ignition) begin
            state_d = DISARMED;
          end else if (bus.driver_door) begin
            state_d = WAIT_DOOR_CLOSE;
          end
        end
        WAIT_DOOR_CLOSE: begin
          if (bus.ignition) begin
            state_d = DISARMED;
          end else if (!bus.driver_door) begin
            state_d  = ARM_COUNT;
            load_en  = 1'b1;
            load_val = LOAD_ARM;
          end
        end
        ARM_COUNT: begin
          // Passenger door and hood are deliberately ignored while re-arming.
          if (bus.ignition) begin
            state_d = DISARMED;
          end else if (bus.driver_door) begin
            state_d = WAIT_DOOR_CLOSE;
          end else if (expired) begin
            state_d = ARMED;
          end
        end
        default: begin
          state_d  = ARMED;
          clear_en = 1'b1;
        end
      endcase
    end
  end

  // Down-counter: load or clear takes priority, otherwise decrement on tick down to zero.
  always_comb begin
    count_d = count_q;
    if (clear_en) begin
      count_d = '0;
    end else if (load_en) begin
      count_d = load_val;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Output decode from the upcoming state so the registered outputs line up with state_out.
  always_comb begin
    siren_d        = (state_d == SOUND_ALARM);
    pump_inhibit_d = (state_d == ARMED) || (state_d == TRIGGERED) ||
                     (state_d == SOUND_ALARM);
    status_led_d   = 1'b0;
    case (state_d)
      ARMED: begin
        // Blink while armed; always restart dark when (re)entering ARMED.
        if (bus.reprogram || (state_q != ARMED)) begin
          status_led_d = 1'b0;
        end else if (tick) begin
          status_led_d = ~status_led_q;
        end else begin
          status_led_d = status_led_q;
        end
      end
      TRIGGERED, SOUND_ALARM: status_led_d = 1'b1;
      default:                status_led_d = 1'b0;
    endcase
  end

  // State, timer and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ARMED;
      count_q        <= '0;
      siren_q        <= 1'b0;
      status_led_q   <= 1'b0;
      pump_inhibit_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      siren_q        <= siren_d;
      status_led_q   <= status_led_d;
      pump_inhibit_q <= pump_inhibit_d;
    end
  end

  assign bus.siren        = siren_q;
  assign bus.status_led   = status_led_q;
  assign bus.pump_inhibit = pump_inhibit_q;
  assign bus.state_out    = state_q;

endmodule

// File: tb/tb_anti_theft_controller.sv
// Self-checking bench for anti_theft_controller: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model that
// tracks "ticks elapsed since the last timer load" against a target.
module tb_anti_theft_controller;

  localparam int P_ARM = 6, P_DRV = 8, P_PAS = 15, P_ALM = 10;
  localparam int M_ARMED = 0, M_TRIG = 1, M_ALARM = 2, M_DIS = 3,
                 M_WOPEN = 4, M_WCLOSE = 5, M_ACNT = 6;

  logic clk;
  logic reset_n;
  anti_theft_controller_if bus();

  anti_theft_controller #(
    .TW(4), .T_ARM_DELAY(P_ARM), .T_DRIVER_DELAY(P_DRV),
    .T_PASSENGER_DELAY(P_PAS), .T_ALARM_ON(P_ALM)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model state
  int m_state;
  int m_since;   // ticks seen since the last load
  int m_target;  // ticks required before the countdown counts as done
  bit m_led, m_siren, m_pump;

  task automatic check(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_ARMED; m_since = 0; m_target = 0;
    m_led = 0; m_siren = 0; m_pump = 1;
  endtask

  // Apply one clock edge's worth of rules to the model using the current inputs.
  task automatic model_step();
    int  ns;
    bit  done, opened, tk;
    ns     = m_state;
    done   = (m_since >= m_target);
    opened = bus.driver_door || bus.passenger_door || bus.hood;
    tk     = bus.one_hz_enable;
    if (bus.reprogram) begin
      ns = M_ARMED; m_target = 0; m_since = 0;
    end else if (bus.ignition && m_state != M_DIS) begin
      ns = M_DIS;
      if (tk) m_since++;
    end else begin
      bit loaded = 0;
      case (m_state)
        M_ARMED:
          if (bus.driver_door) begin ns = M_TRIG; m_target = P_DRV; loaded = 1; end
          else if (opened)     begin ns = M_TRIG; m_target = P_PAS; loaded = 1; end
        M_TRIG:
          if (done) begin ns = M_ALARM; m_target = P_ALM; loaded = 1; end
        M_ALARM:
          if (opened)    begin m_target = P_ALM; loaded = 1; end
          else if (done) ns = M_ARMED;
        M_DIS:    if (!bus.ignition) ns = M_WOPEN;
        M_WOPEN:  if (bus.driver_door) ns = M_WCLOSE;
        M_WCLOSE: if (!bus.driver_door) begin ns = M_ACNT; m_target = P_ARM; loaded = 1; end
        M_ACNT:
          if (bus.driver_door) ns = M_WCLOSE;
          else if (done)       ns = M_ARMED;
        default: ns = M_ARMED;
      endcase
      if (loaded) m_since = 0;
      else if (tk) m_since++;
    end
    m_siren = (ns == M_ALARM);
    m_pump  = (ns inside {M_ARMED, M_TRIG, M_ALARM});
    if (ns == M_ARMED)
      m_led = (m_state == M_ARMED && !bus.reprogram) ? (m_led ^ tk) : 1'b0;
    else
      m_led = (ns == M_TRIG || ns == M_ALARM);
    m_state = ns;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, int'(bus.state_out), m_state);
    check({tag, ".siren"}, int'(bus.siren), int'(m_siren));
    check({tag, ".led"},   int'(bus.status_led), int'(m_led));
    check({tag, ".pump"},  int'(bus.pump_inhibit), int'(m_pump));
  endtask

  // One clock with the currently driven inputs, then compare against the model.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // n ticks, each followed by a tick-free cycle.
  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      bus.one_hz_enable = 1'b1;
      cyc(tag);
      bus.one_hz_enable = 1'b0;
      cyc(tag);
    end
  endtask

  task automatic pulse_reprogram(input string tag);
    bus.reprogram = 1'b1;
    cyc(tag);
    bus.reprogram = 1'b0;
  endtask

  // Assert reset between clock edges and check the outputs fall immediately.
  task automatic async_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2 reset_n = 1'b1;
  endtask

  task automatic inputs_idle();
    bus.one_hz_enable = 0; bus.ignition = 0; bus.driver_door = 0;
    bus.passenger_door = 0; bus.hood = 0; bus.reprogram = 0;
  endtask

  initial begin
    inputs_idle();
    model_reset();
    reset_n = 1'b0;
    #12;
    check_all("reset");
    reset_n = 1'b1;
    cyc("post_reset");

    // 1: armed LED blinks on ticks
    for (int i = 0; i < 5; i++) begin
      bus.one_hz_enable = 1'b1;
      cyc("blink");
      check("blink.led_const", int'(bus.status_led), (i % 2 == 0) ? 1 : 0);
      bus.one_hz_enable = 1'b0;
      cyc("blink_idle");
    end

    // 2: driver door trigger, alarm, tail
    pulse_reprogram("p2_clean");
    bus.driver_door = 1'b1; cyc("p2_open");
    check("p2.trig", int'(bus.state_out), 1);
    bus.driver_door = 1'b0;
    ticks(7, "p2_grace");
    check("p2.still_trig", int'(bus.state_out), 1);
    ticks(1, "p2_expire");
    check("p2.alarm_state", int'(bus.state_out), 2);
    check("p2.siren_on", int'(bus.siren), 1);
    ticks(10, "p2_tail");
    check("p2.rearmed", int'(bus.state_out), 0);
    check("p2.siren_off", int'(bus.siren), 0);

    // 3: simultaneous openings load the driver delay; ignition disarms
    bus.driver_door = 1'b1; bus.passenger_door = 1'b1; cyc("p3_open");
    bus.driver_door = 1'b0; bus.passenger_door = 1'b0;
    ticks(8, "p3_grace");
    check("p3.driver_delay_used", int'(bus.state_out), 2);
    pulse_reprogram("p3_rp");
    bus.driver_door = 1'b1; bus.passenger_door = 1'b1; cyc("p3_open2");
    bus.driver_door = 1'b0; bus.passenger_door = 1'b0;
    ticks(3, "p3_ticks");
    bus.ignition = 1'b1; cyc("p3_ign");
    check("p3.disarmed", int'(bus.state_out), 3);
    check("p3.pump", int'(bus.pump_inhibit), 0);
    check("p3.siren", int'(bus.siren), 0);

    // 4: disarm to rearm
    bus.ignition = 1'b0; cyc("p4_ignoff");
    check("p4.wopen", int'(bus.state_out), 4);
    bus.driver_door = 1'b1; cyc("p4_dopen");
    check("p4.wclose", int'(bus.state_out), 5);
    bus.driver_door = 1'b0; cyc("p4_dclose");
    check("p4.acnt", int'(bus.state_out), 6);
    ticks(3, "p4_t3");
    bus.hood = 1'b1; cyc("p4_hood_ignored");
    check("p4.hood_ignored", int'(bus.state_out), 6);
    bus.hood = 1'b0;
    bus.driver_door = 1'b1; cyc("p4_reopen");
    check("p4.reopen", int'(bus.state_out), 5);
    bus.driver_door = 1'b0; cyc("p4_reclose");
    ticks(5, "p4_t5");
    check("p4.not_yet", int'(bus.state_out), 6);
    ticks(1, "p4_t6");
    check("p4.armed", int'(bus.state_out), 0);
    check("p4.pump", int'(bus.pump_inhibit), 1);

    // 5: hood held in alarm, tail restart
    bus.hood = 1'b1; cyc("p5_open");
    ticks(15, "p5_grace");
    check("p5.alarm", int'(bus.state_out), 2);
    ticks(20, "p5_held");
    check("p5.held_siren", int'(bus.siren), 1);
    bus.hood = 1'b0; cyc("p5_release");
    ticks(5, "p5_tail5");
    bus.hood = 1'b1; cyc("p5_reopen");
    bus.hood = 1'b0; cyc("p5_reclose");
    ticks(9, "p5_tail9");
    check("p5.tail_restarted", int'(bus.siren), 1);
    ticks(1, "p5_tail10");
    check("p5.tail_done", int'(bus.siren), 0);
    check("p5.armed", int'(bus.state_out), 0);

    // 6: reprogram mid-countdown, reset mid-alarm
    bus.driver_door = 1'b1; cyc("p6_open");
    bus.driver_door = 1'b0;
    ticks(4, "p6_t4");
    pulse_reprogram("p6_rp");
    check("p6.rp_state", int'(bus.state_out), 0);
    check("p6.rp_led", int'(bus.status_led), 0);
    cyc("p6_after_rp");
    check("p6.stays_armed", int'(bus.state_out), 0);
    bus.passenger_door = 1'b1; cyc("p6_open2");
    bus.passenger_door = 1'b0;
    ticks(15, "p6_grace");
    check("p6.alarm", int'(bus.siren), 1);
    async_reset("p6_async");
    check("p6.siren_async", int'(bus.siren), 0);
    cyc("p6_after_reset");

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bus.one_hz_enable  = ($urandom_range(0, 2) == 0);
      bus.reprogram      = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 24) == 0) bus.ignition = ~bus.ignition;
      if ($urandom_range(0, 7) == 0)  bus.driver_door = ~bus.driver_door;
      if ($urandom_range(0, 9) == 0)  bus.passenger_door = ~bus.passenger_door;
      if ($urandom_range(0, 11) == 0) bus.hood = ~bus.hood;
      if ($urandom_range(0, 799) == 0) async_reset("rnd_reset");
      else cyc("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
